// File: rtl/secded_decoder_pipe_if.sv
// Stream interface for the SECDED decoder: codeword in, corrected data,
// error flags and statistics out.
interface secded_decoder_pipe_if #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8
);
  localparam int N = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      codeword_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic [PAR_W:0]    pos_error;
  logic              err_single;
  logic              err_double;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_single;
  logic [CNT_W-1:0]  cnt_double;

  modport slave (
    input  in_valid, codeword_in, out_ready, clr_cnt,
    output in_ready, out_valid, data_out, pos_error,
    output err_single, err_double, cnt_single, cnt_double
  );

  modport master (
    output in_valid, codeword_in, out_ready, clr_cnt,
    input  in_ready, out_valid, data_out, pos_error,
    input  err_single, err_double, cnt_single, cnt_double
  );
endinterface

// File: rtl/secded_decoder_pipe.sv
// Two-stage Hamming SECDED decoder: syndrome/parity from the S1 register,
// corrected data and flags in S2, saturating error counters.
module secded_decoder_pipe #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  secded_decoder_pipe_if.slave bus
);
  localparam int N = DATA_W + PAR_W + 1;
  localparam logic [PAR_W:0] LAST = (PAR_W+1)'(N - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  if (DATA_W < 1) begin : g_dw_chk
    $error("DATA_W must be at least 1");
  end
  if ((1 << PAR_W) < N) begin : g_pw_chk
    $error("PAR_W too small: 2**PAR_W < DATA_W+PAR_W+1");
  end

  logic              w_adv;
  logic              w_xfer;
  logic [PAR_W-1:0]  w_s;
  logic              w_g;
  logic              w_in_range;
  logic              w_single;
  logic              w_double;
  logic [DATA_W-1:0] w_data;

  logic              r1_valid;
  logic [N-1:0]      r1_cw;
  logic              r2_valid;
  logic [DATA_W-1:0] r2_data;
  logic [PAR_W:0]    r2_pos;
  logic              r2_single;
  logic              r2_double;
  logic [CNT_W-1:0]  r_cnt_s;
  logic [CNT_W-1:0]  r_cnt_d;

  assign w_adv  = !r2_valid || bus.out_ready;
  assign w_xfer = r2_valid && bus.out_ready;

  always_comb begin
    w_s = '0;
    for (int j = 1; j < N; j++)
      if (r1_cw[j]) w_s = w_s ^ PAR_W'(j);
  end

  assign w_g        = ^r1_cw;
  assign w_in_range = {1'b0, w_s} <= LAST;
  assign w_single   = w_g && w_in_range;
  assign w_double   = (!w_g && (w_s != '0)) || (w_g && !w_in_range);

  // Data bits fill non-power-of-two positions in ascending order;
  // shifting in from the top leaves the first one at bit 0.
  always_comb begin
    w_data = '0;
    for (int j = 3; j < N; j++)
      if ((j & (j - 1)) != 0)
        w_data = (w_data >> 1) |
          (DATA_W'(r1_cw[j] ^ (w_single && (w_s == PAR_W'(j))))
            << (DATA_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_cw     <= '0;
      r2_valid  <= 1'b0;
      r2_data   <= '0;
      r2_pos    <= '0;
      r2_single <= 1'b0;
      r2_double <= 1'b0;
    end else if (w_adv) begin
      r1_valid  <= bus.in_valid;
      r1_cw     <= bus.codeword_in;
      r2_valid  <= r1_valid;
      r2_data   <= w_data;
      r2_pos    <= {w_g, w_s};
      r2_single <= r1_valid && w_single;
      r2_double <= r1_valid && w_double;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      r_cnt_s <= '0;
      r_cnt_d <= '0;
    end else begin
      if (w_xfer && r2_single && (r_cnt_s != CMAX))
        r_cnt_s <= r_cnt_s + 1'b1;
      if (w_xfer && r2_double && (r_cnt_d != CMAX))
        r_cnt_d <= r_cnt_d + 1'b1;
    end
  end

  assign bus.in_ready   = w_adv;
  assign bus.out_valid  = r2_valid;
  assign bus.data_out   = r2_data;
  assign bus.pos_error  = r2_pos;
  assign bus.err_single = r2_single;
  assign bus.err_double = r2_double;
  assign bus.cnt_single = r_cnt_s;
  assign bus.cnt_double = r_cnt_d;
endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench: 8-bit codewords with 2-bit counters, plus a
// DATA_W=8/PAR_W=4 instance for the out-of-range syndrome case.
module tb_secded_decoder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  secded_decoder_pipe_if #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) a_if ();
  secded_decoder_pipe_if #(.DATA_W(8), .PAR_W(4), .CNT_W(8)) b_if ();

  secded_decoder_pipe #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  secded_decoder_pipe #(.DATA_W(8), .PAR_W(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic one(input string nm, input logic [7:0] cw,
                     input logic [3:0] ed, input logic [3:0] ep,
                     input logic es, input logic edb,
                     input logic clr);
    @(negedge clk);
    a_if.in_valid    = 1'b1;
    a_if.codeword_in = cw;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    @(negedge clk);
    check({nm, ".valid"}, a_if.out_valid, 1);
    check({nm, ".data"}, a_if.data_out, ed);
    check({nm, ".pos"}, a_if.pos_error, ep);
    check({nm, ".single"}, a_if.err_single, es);
    check({nm, ".double"}, a_if.err_double, edb);
    a_if.clr_cnt = clr;
    @(negedge clk);
    a_if.clr_cnt = 1'b0;
  endtask

  logic [7:0] bp_cw [3];
  logic [3:0] bp_d  [3];
  logic [3:0] bp_p  [3];
  int idx_in, idx_out, stall, extra;
  bit seen;
  logic [3:0] snap_d, snap_p;

  initial begin
    bp_cw = '{8'hAA, 8'h8A, 8'hCA};
    bp_d  = '{4'hB, 4'hB, 4'hD};
    bp_p  = '{4'h0, 4'hD, 4'h3};
    a_if.in_valid = 1'b0; a_if.codeword_in = '0;
    a_if.out_ready = 1'b1; a_if.clr_cnt = 1'b0;
    b_if.in_valid = 1'b0; b_if.codeword_in = '0;
    b_if.out_ready = 1'b1; b_if.clr_cnt = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.valid", a_if.out_valid, 0);
    check("rst.in_ready", a_if.in_ready, 1);
    check("rst.data", a_if.data_out, 0);
    check("rst.pos", a_if.pos_error, 0);
    check("rst.cnt_s", a_if.cnt_single, 0);
    check("rst.cnt_d", a_if.cnt_double, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", a_if.in_ready, 1);

    one("clean", 8'hAA, 4'hB, 4'h0, 0, 0, 0);
    check("clean.cnt_s", a_if.cnt_single, 0);
    check("clean.cnt_d", a_if.cnt_double, 0);
    one("sgl5", 8'h8A, 4'hB, 4'hD, 1, 0, 0);
    check("sgl5.cnt_s", a_if.cnt_single, 1);
    one("sgl0", 8'hAB, 4'hB, 4'h8, 1, 0, 0);
    check("sgl0.cnt_s", a_if.cnt_single, 2);
    one("dbl", 8'hCA, 4'hD, 4'h3, 0, 1, 0);
    check("dbl.cnt_d", a_if.cnt_double, 1);
    check("dbl.cnt_s", a_if.cnt_single, 2);

    // Wide instance: g=1,s=14 beyond N-1=12, then a single error at 12.
    @(negedge clk);
    b_if.in_valid = 1'b1; b_if.codeword_in = 13'h1005;
    @(negedge clk);
    b_if.codeword_in = 13'h1000;
    @(negedge clk);
    b_if.in_valid = 1'b0;
    check("w14.valid", b_if.out_valid, 1);
    check("w14.data", b_if.data_out, 8'h80);
    check("w14.pos", b_if.pos_error, 5'h1E);
    check("w14.single", b_if.err_single, 0);
    check("w14.double", b_if.err_double, 1);
    @(negedge clk);
    check("w12.data", b_if.data_out, 8'h00);
    check("w12.pos", b_if.pos_error, 5'h1C);
    check("w12.single", b_if.err_single, 1);
    check("w12.double", b_if.err_double, 0);
    @(negedge clk);
    check("w.cnt_s", b_if.cnt_single, 1);
    check("w.cnt_d", b_if.cnt_double, 1);

    idx_in = 0; idx_out = 0; stall = 0; seen = 0;
    snap_d = '0; snap_p = '0;
    for (int cyc = 0; cyc < 30 && idx_out < 3; cyc++) begin
      @(negedge clk);
      if (a_if.out_valid && !seen) begin
        seen = 1; stall = 3;
        snap_d = a_if.data_out; snap_p = a_if.pos_error;
      end
      a_if.out_ready   = (stall == 0);
      a_if.in_valid    = (idx_in < 3);
      a_if.codeword_in = bp_cw[idx_in < 3 ? idx_in : 2];
      #1;
      if (stall > 0) begin
        check("bp.in_ready", a_if.in_ready, 0);
        check("bp.hold_v", a_if.out_valid, 1);
        check("bp.hold_d", a_if.data_out, snap_d);
        check("bp.hold_p", a_if.pos_error, snap_p);
        stall--;
      end
      if (a_if.out_valid && a_if.out_ready) begin
        check($sformatf("bp.d%0d", idx_out), a_if.data_out, bp_d[idx_out]);
        check($sformatf("bp.p%0d", idx_out), a_if.pos_error, bp_p[idx_out]);
        idx_out++;
      end
      if (a_if.in_valid && a_if.in_ready) idx_in++;
    end
    check("bp.count", idx_out, 3);
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_if.out_valid) extra++;
    end
    check("bp.dup", extra, 0);
    check("bp.cnt_s", a_if.cnt_single, 3);
    check("bp.cnt_d", a_if.cnt_double, 2);

    one("sat1", 8'h8A, 4'hB, 4'hD, 1, 0, 0);
    one("sat2", 8'hAB, 4'hB, 4'h8, 1, 0, 0);
    check("sat.cnt_s", a_if.cnt_single, 3);
    check("sat.cnt_d", a_if.cnt_double, 2);
    one("clr", 8'h8A, 4'hB, 4'hD, 1, 0, 1);
    check("clr.cnt_s", a_if.cnt_single, 0);
    check("clr.cnt_d", a_if.cnt_double, 0);
    one("again", 8'h8A, 4'hB, 4'hD, 1, 0, 0);
    check("again.cnt_s", a_if.cnt_single, 1);

    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.codeword_in = 8'hAA;
    @(negedge clk);
    a_if.codeword_in = 8'h8A;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst.valid", a_if.out_valid, 0);
    check("mid_rst.in_ready", a_if.in_ready, 1);
    check("mid_rst.cnt_s", a_if.cnt_single, 0);
    check("mid_rst.data", a_if.data_out, 0);
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_if.out_valid) extra++;
    end
    check("mid_rst.stale", extra, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder/corrector. It generalises the fixed 4-bit syndrome comparison to any data width.
- Computes the syndrome of a received codeword, locates and corrects single-bit errors, and flags double-bit errors.
- Keeps saturating error statistics.
- Sits between the channel/receive register and the data consumer, with valid/ready streaming on both sides.

Parameters:
- DATA_W, 4, number of data bits (≥1).
- PAR_W, 3, number of Hamming parity bits. Must satisfy 2^PAR_W ≥ DATA_W+PAR_W+1; violation is an elaboration error.
- CNT_W, 8, width of each error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  codeword_in valid.
- in_ready  output  1  block can accept codeword this cycle.
- codeword_in  input  DATA_W+PAR_W+1  received codeword; bit 0 = overall parity g, bits 1..N-1 = Hamming positions (N = DATA_W+PAR_W+1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- data_out  output  DATA_W  corrected data.
- pos_error  output  PAR_W+1  {g, s[PAR_W-1:0]}: overall-parity flag and syndrome.
- err_single  output  1  single error detected and corrected.
- err_double  output  1  uncorrectable error.
- clr_cnt  input  1  synchronous counter clear.
- cnt_single  output  CNT_W  saturating single-error count.
- cnt_double  output  CNT_W  saturating double-error count.

Behaviour:
- Codeword layout
  - Positions that are powers of two (1, 2, 4, …) are parity bits p1, p2, p4, ….
  - Remaining positions 3, 5, 6, 7, 9, … carry data bits in ascending order; data bit 0 is at position 3.
  - Bit 0 is even overall parity over bits 1..N-1.
- Syndrome and overall parity
  - s = XOR of the indices j (1..N-1) where codeword bit j = 1.
  - g = XOR of all N bits.
- Classification
  - s=0, g=0: no error; data passed through.
  - g=1, s ≤ N-1: single error at position s. Invert that bit before data extraction. s=0 means bit 0 flipped; data unaffected.
  - g=0, s≠0: double error. err_double=1; data_out = uncorrected data bits.
  - g=1, s > N-1 (only possible when N < 2^PAR_W): treated as double error.
  - err_single and err_double are never both 1.
- Pipeline
  - Two register stages.
  - S1 registers the codeword and computes s and g.
  - S2 registers the corrected data, pos_error and flags.
  - Latency: 2 clocks from accepted input to out_valid.
- Handshake
  - adv = !out_valid || out_ready.
  - in_ready = adv, driven combinationally from out_valid and out_ready.
  - Both stages advance only when adv=1. Bubbles (invalid stage) propagate as valid=0.
  - Throughput is 1 codeword/cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, all outputs hold stable and no input is accepted.
- Counters
  - Increment on the transfer cycle (out_valid && out_ready) when the corresponding flag is 1.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt=1 zeroes both counters next edge. Clear wins over a simultaneous increment.
- Reset
  - rst=1 zeroes all stage valids, data_out, pos_error, err_single, err_double, cnt_single and cnt_double.
  - A reset mid-stream discards in-flight codewords; no output is produced for them.
  - in_ready is 1 during and right after reset (out_valid=0).

Test Plan:
- DATA_W=4, PAR_W=3, data 4'hB encoded as codeword_in=8'hAA, out_ready=1 → after 2 cycles: out_valid=1, data_out=4'hB, pos_error=4'h0, both flags 0, counters unchanged.
- Single error: codeword_in=8'h8A (position 5 flipped) → data_out=4'hB, pos_error=4'hD, err_single=1, cnt_single=1.
- Overall-parity error: codeword_in=8'hAB → data_out=4'hB, pos_error=4'h8, err_single=1.
- Double error: codeword_in=8'hCA (positions 5 and 6 flipped) → pos_error=4'h3, err_double=1, err_single=0, cnt_double increments. Configured with DATA_W=8, PAR_W=4 and a g=1, s=14 pattern → err_double=1.
- Backpressure:
  - Stream 8'hAA, 8'h8A, 8'hCA back-to-back with out_ready held low for 3 cycles after the first out_valid.
  - Required: in_ready=0 while stalled, outputs stable, all three results delivered in order with no loss or duplication.
- Counter saturation and clear, run with CNT_W=2:
  - Send 5 single-error codewords → cnt_single=3.
  - Assert clr_cnt on the same cycle as a single-error transfer → cnt_single=0 next cycle.
  - Assert rst mid-stream → out_valid=0 next cycle; no stale output.
